// File: rtl/lsu_mem_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states,
// default watchdog limit and the alignment legality check.
package lsu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StRmwWr,
    StWr,
    StResp
  } lsu_state_e;

  // Illegal size code or an access that straddles its natural alignment.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align_unit.sv
// Combinational byte-lane steering: extracts/extends sub-word load data and
// merges sub-word store data into a freshly read memory word (little-endian).
module lsu_align_unit
  import lsu_mem_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        is_signed_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [31:0] shifted;

  // Load path: shift the addressed lane down, then sign- or zero-fill.
  always_comb begin
    shifted     = rd_data_i >> {lane_i, 3'b000};
    load_data_o = rd_data_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{is_signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_o = {{16{is_signed_i & shifted[15]}}, shifted[15:0]};
      default: load_data_o = rd_data_i;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the read word.
  always_comb begin
    store_word_o = rd_data_i;
    case (size_i)
      SZ_BYTE: store_word_o[{lane_i, 3'b000} +: 8]       = wr_data_i[7:0];
      SZ_HALF: store_word_o[{lane_i[1], 4'b0000} +: 16]  = wr_data_i[15:0];
      default: store_word_o = wr_data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of a word-addressed data memory. One request
// at a time; sub-word stores use read-modify-write.
// Optional macro LSU_TIMEOUT_EN adds a per-access watchdog of TIMEOUT cycles.
module lsu_mem_ctrl
  import lsu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_wr_done,
  input  logic              mem_rd_done
);

  if (DATA_W != 32 || TIMEOUT == 0) begin : gen_param_check
    $error("lsu_mem_ctrl: DATA_W must be 32 and TIMEOUT nonzero");
  end

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;  // store data, later the merged RMW word
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       load_data, store_word;
  logic              timeout_hit;

  lsu_align_unit u_align (
    .lane_i       (lane_q),
    .size_i       (size_q),
    .is_signed_i  (signed_q),
    .rd_data_i    (mem_rd_data),
    .wr_data_i    (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_wait;

  // Watchdog: restarts on every state change, counts while waiting on memory.
  always_comb begin
    in_wait     = state_q inside {StRd, StRmwRd, StWr, StRmwWr};
    cnt_d       = (in_wait && state_d == state_q) ? cnt_q + 1'b1 : '0;
    timeout_hit = in_wait && (cnt_q == CntW'(TIMEOUT - 1));
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and captured-request logic.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    lane_d   = lane_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          word_d   = req_addr[ADDR_W+1:2];
          lane_d   = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (is_bad_access(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (!req_we)           state_d = StRd;
          else if (req_size == SZ_WORD)   state_d = StWr;
          else                            state_d = StRmwRd;
        end
      end
      StRd, StRmwRd: begin
        if (mem_rd_done) begin
          if (state_q == StRd) begin
            rdata_d = load_data;
            state_d = StResp;
          end else begin
            wdata_d = store_word;
            state_d = StRmwWr;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StWr, StRmwWr: begin
        if (mem_wr_done) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      word_q   <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state; data buses are zero when idle.
  always_comb begin
    req_ready      = (state_q == StIdle);
    mem_read       = (state_q == StRd) || (state_q == StRmwRd);
    mem_write      = (state_q == StWr) || (state_q == StRmwWr);
    mem_read_addr  = mem_read ? word_q : '0;
    mem_write_addr = mem_write ? word_q : '0;
    mem_wr_data    = mem_write ? wdata_q : '0;
    rsp_valid      = (state_q == StResp);
    rsp_rdata      = rsp_valid ? rdata_q : '0;
    rsp_err        = rsp_valid & err_q;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small behavioural memory responder.
module tb_lsu_mem_ctrl;
  import lsu_mem_pkg::*;

  localparam int LAT   = 2;    // memory answers on the 3rd strobe cycle
  localparam int BOUND = 200;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [9:0]  mem_read_addr, mem_write_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic        mem_wr_done, mem_rd_done;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [0:15];
  int          wait_cnt, rd_count, wr_count, overlap_count;
  logic [9:0]  last_wr_addr;
  logic        hang, mdl_rd_done, mdl_wr_done, inj_rd_done, inj_wr_done;

  assign mem_rd_done = mdl_rd_done | inj_rd_done;
  assign mem_wr_done = mdl_wr_done | inj_wr_done;

  lsu_mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_rd_data    (mem_rd_data),
    .mem_wr_done    (mem_wr_done),
    .mem_rd_done    (mem_rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: done pulse after LAT waiting cycles of a held strobe.
  always @(negedge clk) begin
    mdl_rd_done = 1'b0;
    mdl_wr_done = 1'b0;
    if (mem_read && mem_write) overlap_count++;
    if (hang || (!mem_read && !mem_write)) wait_cnt = 0;
    else if (wait_cnt < LAT) wait_cnt++;
    else begin
      wait_cnt = 0;
      if (mem_read) begin
        mdl_rd_done = 1'b1;
        mem_rd_data = model[mem_read_addr[3:0]];
        rd_count++;
      end else begin
        mdl_wr_done = 1'b1;
        model[mem_write_addr[3:0]] = mem_wr_data;
        last_wr_addr = mem_write_addr;
        wr_count++;
      end
    end
  end

  // Issue one request from idle; lat = edges from acceptance to the response
  // cycle, pulses = consecutive cycles rsp_valid stayed high (0 if none).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int pulses);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    lat = 1; pulses = 0; rd = '0; er = 1'b0;
    while (!rsp_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid) begin
      rd = rsp_rdata; er = rsp_err;
      while (rsp_valid && pulses < 4) begin
        pulses++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", req_ready); end
    checks++; if ({rsp_valid, rsp_err, mem_read, mem_write} !== 4'b0) begin failures++; $display("FAIL reset_ctrl_outs got=%b exp=0000", {rsp_valid, rsp_err, mem_read, mem_write}); end
    checks++; if ({rsp_rdata, mem_wr_data, mem_read_addr, mem_write_addr} !== 84'h0) begin failures++; $display("FAIL reset_data_outs got=%h exp=0", {rsp_rdata, mem_wr_data, mem_read_addr, mem_write_addr}); end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic er; int lat, pl, r0, w0;
    r0 = rd_count; w0 = wr_count;
    do_req(1'b1, SZ_WORD, 1'b0, 12'h000, 32'h7ABC9C86, rd, er, lat, pl);
    checks++; if (model[0] !== 32'h7ABC9C86) begin failures++; $display("FAIL wstore_mem got=%h exp=7abc9c86", model[0]); end
    checks++; if ({rd_count - r0, wr_count - w0} !== {32'd0, 32'd1}) begin failures++; $display("FAIL wstore_accesses got=rd%0d/wr%0d exp=rd0/wr1", rd_count - r0, wr_count - w0); end
    checks++; if (last_wr_addr !== 10'd0) begin failures++; $display("FAIL wstore_addr got=%0d exp=0", last_wr_addr); end
    checks++; if ({er, rd} !== 33'h0) begin failures++; $display("FAIL wstore_rsp got=%b/%h exp=0/0", er, rd); end
    checks++; if (lat !== LAT + 2 || pl !== 1) begin failures++; $display("FAIL wstore_timing got=lat%0d/pulses%0d exp=lat4/pulses1", lat, pl); end
    do_req(1'b0, SZ_WORD, 1'b1, 12'h000, 32'h0, rd, er, lat, pl);
    checks++; if (rd !== 32'h7ABC9C86 || er !== 1'b0) begin failures++; $display("FAIL wload_rsp got=%h/%b exp=7abc9c86/0", rd, er); end
    checks++; if (lat !== LAT + 2 || pl !== 1) begin failures++; $display("FAIL wload_timing got=lat%0d/pulses%0d exp=lat4/pulses1", lat, pl); end
  endtask

  task automatic test_subword_loads();
    logic [1:0]  sz  [6] = '{SZ_BYTE, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_HALF};
    logic        sg  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [11:0] ad  [6] = '{12'd1, 12'd2, 12'd2, 12'd0, 12'd0, 12'd0};
    logic [31:0] exp [6] = '{32'hFFFFFF9C, 32'h00007ABC, 32'h00007ABC,
                             32'h00000086, 32'hFFFFFF86, 32'hFFFF9C86};
    logic [31:0] rd; logic er; int lat, pl;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, sz[i], sg[i], ad[i], 32'hFFFFFFFF, rd, er, lat, pl);
      checks++; if (rd !== exp[i] || er !== 1'b0) begin failures++; $display("FAIL subload_%0d got=%h/%b exp=%h/0", i, rd, er, exp[i]); end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; logic er; int lat, pl, r0, w0;
    r0 = rd_count; w0 = wr_count;
    do_req(1'b1, SZ_BYTE, 1'b1, 12'd3, 32'hAAAAAA55, rd, er, lat, pl);
    checks++; if (model[0] !== 32'h55BC9C86) begin failures++; $display("FAIL rmw_byte_mem got=%h exp=55bc9c86", model[0]); end
    checks++; if ({rd_count - r0, wr_count - w0} !== {32'd1, 32'd1}) begin failures++; $display("FAIL rmw_accesses got=rd%0d/wr%0d exp=rd1/wr1", rd_count - r0, wr_count - w0); end
    checks++; if (lat !== 2 * LAT + 3 || pl !== 1 || er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL rmw_rsp got=lat%0d/pulses%0d/%b/%h exp=lat7/pulses1/0/0", lat, pl, er, rd); end
    model[1] = 32'hDEADBEEF;
    do_req(1'b1, SZ_HALF, 1'b0, 12'd6, 32'h99991234, rd, er, lat, pl);
    checks++; if (model[1] !== 32'h1234BEEF || last_wr_addr !== 10'd1) begin failures++; $display("FAIL rmw_half_mem got=%h@%0d exp=1234beef@1", model[1], last_wr_addr); end
  endtask

  task automatic test_errors();
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{SZ_HALF, SZ_WORD, 2'b11, SZ_WORD};
    logic [11:0] ad [4] = '{12'd1, 12'd6, 12'd0, 12'd2};
    logic [31:0] rd; logic er; int lat, pl, r0, w0;
    for (int i = 0; i < 4; i++) begin
      r0 = rd_count; w0 = wr_count;
      do_req(we[i], sz[i], 1'b1, ad[i], 32'h12345678, rd, er, lat, pl);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err_rsp_%0d got=%b/%h exp=1/0", i, er, rd); end
      checks++; if (lat !== 1 || pl !== 1 || req_ready !== 1'b1) begin failures++; $display("FAIL err_timing_%0d got=lat%0d/pulses%0d/rdy%b exp=lat1/pulses1/rdy1", i, lat, pl, req_ready); end
      checks++; if (rd_count != r0 || wr_count != w0) begin failures++; $display("FAIL err_noaccess_%0d got=rd%0d/wr%0d exp=0/0", i, rd_count - r0, wr_count - w0); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, pl, seen;
    hang = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 12'd0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL midrst_pre_read got=%b exp=1", mem_read); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({mem_read, rsp_valid, req_ready} !== 3'b001) begin failures++; $display("FAIL midrst_outs got=rd%b/rsp%b/rdy%b exp=0/0/1", mem_read, rsp_valid, req_ready); end
    hang = 1'b0;
    inj_rd_done = 1'b1; inj_wr_done = 1'b1;
    @(negedge clk);
    inj_rd_done = 1'b0; inj_wr_done = 1'b0;
    seen = 0;
    repeat (4) begin
      if (rsp_valid || !req_ready || mem_read || mem_write) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_late_done got=%0d busy cycles exp=0", seen); end
    do_req(1'b0, SZ_WORD, 1'b0, 12'd0, 32'h0, rd, er, lat, pl);
    checks++; if (rd !== 32'h55BC9C86 || er !== 1'b0) begin failures++; $display("FAIL midrst_recover got=%h/%b exp=55bc9c86/0", rd, er); end
  endtask

  task automatic test_hang();
    int r0;
`ifdef LSU_TIMEOUT_EN
    logic [31:0] rd; logic er; int lat, pl;
    hang = 1'b1;
    r0 = rd_count;
    do_req(1'b0, SZ_WORD, 1'b0, 12'd0, 32'h0, rd, er, lat, pl);
    hang = 1'b0;
    checks++; if (er !== 1'b1 || rd !== 32'h0 || rd_count != r0) begin failures++; $display("FAIL timeout_rsp got=%b/%h exp=1/0", er, rd); end
    checks++; if (lat !== 16 || pl !== 1) begin failures++; $display("FAIL timeout_timing got=lat%0d/pulses%0d exp=lat16/pulses1", lat, pl); end
`else
    int high, rsp;
    hang = 1'b1;
    r0 = rd_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 12'd0;
    @(negedge clk);
    req_valid = 1'b0;
    high = 0; rsp = 0;
    repeat (40) begin
      if (mem_read) high++;
      if (rsp_valid) rsp++;
      @(negedge clk);
    end
    checks++; if (high !== 40 || rsp !== 0 || rd_count != r0) begin failures++; $display("FAIL hang_waits got=read%0d/rsp%0d exp=read40/rsp0", high, rsp); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
`endif
    checks++; if (overlap_count !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_count); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rd_data = '0;
    hang = 1'b0; inj_rd_done = 1'b0; inj_wr_done = 1'b0;
    mdl_rd_done = 1'b0; mdl_wr_done = 1'b0;
    wait_cnt = 0; rd_count = 0; wr_count = 0; overlap_count = 0; last_wr_addr = '1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_rmw();
    test_errors();
    test_reset_mid();
    test_hang();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
